memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  MEM stage of the 5-stage RV32I pipeline. Sits between the EX/MEM register and write_back.
//  Decodes the ALU-computed address into one of four data banks and formats store data/byte enables.
//  Runs a req/ack handshake with slow bank 3, with timeout, stalling the pipeline while waiting.
//  Registers the MEM/WB pipeline outputs consumed by write_back.
// PARAMETERS
//  WIDTH       32  data/register width
//  BANK_AW     10  word-address width of each bank
//  BANK_LSB    12  address bit where 2-bit bank select starts (sel = addr[BANK_LSB+1:BANK_LSB])
//  TIMEOUT     15  max cycles in WAIT3 before giving up (4-bit counter)
// PORTS
//  clk                 in   1        clock
//  rst_n               in   1        async active-low reset
//  valid_EXMEM         in   1        instruction in MEM is real (0 = bubble)
//  ALU_out_EXMEM       in   WIDTH    ALU result / effective address
//  rs2_data_EXMEM      in   WIDTH    store data
//  pc_4_EXMEM          in   WIDTH    PC+4
//  funct3_EXMEM        in   3        load/store size code
//  mem_rd_en_EXMEM     in   1        load
//  mem_wr_en_EXMEM     in   1        store
//  reg_wr_ctrl_EXMEM   in   2        0 ALU, 1 PC+4, 2 memory
//  rd_EXMEM            in   5        dest register
//  reg_wr_en_EXMEM     in   1        dest write enable
//  mem_addr            out  BANK_AW  word address to all banks = addr[BANK_AW+1:2]
//  mem_wr_data         out  WIDTH    lane-replicated store data
//  mem_byte_en         out  4        store byte enables
//  mem_en              out  4        one-hot bank enable (comb)
//  mem_wr              out  1        write strobe (comb)
//  mem3_req            out  1        bank-3 request (registered level)
//  mem3_ack            in   1        bank-3 done, 1-cycle pulse
//  mem3_rd_data        in   WIDTH    bank-3 read data, valid with ack
//  stall_MEM           out  1        hold PC/IF/ID/EX regs
//  misalign_exc        out  1        1-cycle pulse, registered
//  bus_err             out  1        1-cycle pulse, registered, on bank-3 timeout
//  ALU_out_MEMWB, pc_4_MEMWB, funct3_MEMWB, rd_MEMWB, reg_wr_ctrl_MEMWB, reg_wr_en_MEMWB  out  registered copies
//  mem_sel_MEMWB       out  2        registered bank select
//  byte_offset_MEMWB   out  2        registered addr[1:0]
//  mem3_rd_data_MEMWB  out  WIDTH    bank-3 data captured on ack
// BEHAVIOUR
//  - Reset: all registered outputs 0; FSM=IDLE; counter 0; mem3_req 0.
//  - acc = valid & (rd_en|wr_en) & ~misaligned.
//  - Misaligned: W and addr[1:0]!=0; H/HU and addr[0]=1.
//    Misaligned access: no mem_en/mem_wr; misalign_exc pulses next cycle; MEMWB gets reg_wr_en=0.
//  - Store formatting:
//    SB: data={4{rs2[7:0]}}, be=4'b0001<<off
//    SH: data={2{rs2[15:0]}}, be=4'b0011<<off
//    SW: data=rs2, be=4'b1111
//    Loads: be=0.
//  - Banks 0-2: mem_en[sel]=acc, 1-cycle sync read; no stall.
//  - FSM IDLE -> WAIT3 when acc & sel==3. Same edge: mem3_req<=1, cnt<=0.
//    stall_MEM=1 combinationally in the entry cycle and in WAIT3 until exit.
//    mem_en[3]/mem_addr/data stay driven from the held EX/MEM inputs.
//  - WAIT3 + mem3_ack: capture mem3_rd_data into mem3_rd_data_MEMWB; req<=0; ->IDLE.
//    stall_MEM=0 that cycle; MEMWB latches the instruction.
//  - WAIT3, cnt==TIMEOUT, no ack: req<=0; bus_err pulse; MEMWB latches the instruction with reg_wr_en=0; ->IDLE.
//    ack and timeout in the same cycle: ack wins.
//  - MEMWB regs: load every cycle stall_MEM=0. While stalled, load a bubble (reg_wr_en_MEMWB=0, rest don't-care).
//    Non-valid EX/MEM input also yields reg_wr_en_MEMWB=0.
//  - mem3_ack while IDLE is ignored. rst_n low in WAIT3 drops req asynchronously and returns to IDLE.
// TESTING
//  - SB x5=0x000000AB to 0x00000003 -> mem_en=0001, be=1000, data=0xABABABAB, no stall.
//  - LW from 0x3004, ack after 3 cycles with 0xDEADBEEF -> stall 4 cycles, mem_sel_MEMWB=3,
//    mem3_rd_data_MEMWB=0xDEADBEEF, reg_wr_en_MEMWB=1.
//  - LH at 0x1001 -> no mem_en, misalign_exc 1 pulse, reg_wr_en_MEMWB=0.
//  - Bank-3 store, no ack -> bus_err after 16 WAIT3 cycles, req drops, FSM back to IDLE.
//  - rst_n low during WAIT3 -> mem3_req=0 immediately; after release, LW 0x0000 completes in 1 cycle.
//  - Ack on the exact timeout cycle -> data captured, no bus_err.

Source files
------------

// File: rtl/memory_access.sv
// MEM stage of the RV32I pipeline: bank decode, store formatting, a req/ack
// handshake with slow bank 3 (with timeout), and the MEM/WB pipeline register.
module memory_access #(
  parameter int WIDTH    = 32,
  parameter int BANK_AW  = 10,
  parameter int BANK_LSB = 12,
  parameter int TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_EXMEM,
  input  logic [WIDTH-1:0]   ALU_out_EXMEM,
  input  logic [WIDTH-1:0]   rs2_data_EXMEM,
  input  logic [WIDTH-1:0]   pc_4_EXMEM,
  input  logic [2:0]         funct3_EXMEM,
  input  logic               mem_rd_en_EXMEM,
  input  logic               mem_wr_en_EXMEM,
  input  logic [1:0]         reg_wr_ctrl_EXMEM,
  input  logic [4:0]         rd_EXMEM,
  input  logic               reg_wr_en_EXMEM,
  output logic [BANK_AW-1:0] mem_addr,
  output logic [WIDTH-1:0]   mem_wr_data,
  output logic [3:0]         mem_byte_en,
  output logic [3:0]         mem_en,
  output logic               mem_wr,
  output logic               mem3_req,
  input  logic               mem3_ack,
  input  logic [WIDTH-1:0]   mem3_rd_data,
  output logic               stall_MEM,
  output logic               misalign_exc,
  output logic               bus_err,
  output logic [WIDTH-1:0]   ALU_out_MEMWB,
  output logic [WIDTH-1:0]   pc_4_MEMWB,
  output logic [2:0]         funct3_MEMWB,
  output logic [4:0]         rd_MEMWB,
  output logic [1:0]         reg_wr_ctrl_MEMWB,
  output logic               reg_wr_en_MEMWB,
  output logic [1:0]         mem_sel_MEMWB,
  output logic [1:0]         byte_offset_MEMWB,
  output logic [WIDTH-1:0]   mem3_rd_data_MEMWB
);

  localparam int CNT_W = 4;

  typedef enum logic {S_IDLE, S_WAIT3} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;

  logic [1:0] w_off;
  logic [1:0] w_sel;
  logic       w_mem_op;
  logic       w_bad_align;
  logic       w_acc;
  logic       w_mis;
  logic       w_start3;
  logic       w_ack3;
  logic       w_tmo;

  assign w_off    = ALU_out_EXMEM[1:0];
  assign w_sel    = ALU_out_EXMEM[BANK_LSB+1:BANK_LSB];
  assign w_mem_op = valid_EXMEM & (mem_rd_en_EXMEM | mem_wr_en_EXMEM);

  // funct3[1:0]: 00 byte, 01 half, 10 word (bit 2 only selects unsigned loads)
  assign w_bad_align = ((funct3_EXMEM[1:0] == 2'b10) && (w_off != 2'b00)) ||
                       ((funct3_EXMEM[1:0] == 2'b01) && w_off[0]);
  assign w_acc = w_mem_op & ~w_bad_align;
  assign w_mis = w_mem_op & w_bad_align;

  assign w_start3 = (r_state == S_IDLE) && w_acc && (w_sel == 2'd3);
  assign w_ack3   = (r_state == S_WAIT3) && mem3_ack;
  // An ack arriving on the timeout cycle takes priority over the bus error.
  assign w_tmo    = (r_state == S_WAIT3) && !mem3_ack && (r_cnt == CNT_W'(TIMEOUT));

  // Bank interface, driven straight from the (held) EX/MEM inputs.
  assign mem_addr = ALU_out_EXMEM[BANK_AW+1:2];
  assign mem_en   = w_acc ? (4'b0001 << w_sel) : 4'b0000;
  assign mem_wr   = w_acc & mem_wr_en_EXMEM;
  assign mem3_req = r_req;

  always_comb begin
    mem_wr_data = rs2_data_EXMEM;
    mem_byte_en = 4'b0000;
    case (funct3_EXMEM[1:0])
      2'b00: begin
        mem_wr_data = {(WIDTH/8){rs2_data_EXMEM[7:0]}};
        mem_byte_en = 4'b0001 << w_off;
      end
      2'b01: begin
        mem_wr_data = {(WIDTH/16){rs2_data_EXMEM[15:0]}};
        mem_byte_en = 4'b0011 << w_off;
      end
      default: begin
        mem_wr_data = rs2_data_EXMEM;
        mem_byte_en = 4'b1111;
      end
    endcase
    if (!(w_acc && mem_wr_en_EXMEM))
      mem_byte_en = 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start3) begin
        r_cnt <= '0;
        r_req <= 1'b1;
      end else if (r_state == S_WAIT3) begin
        if (w_ack3 || w_tmo)
          r_req <= 1'b0;
        else
          r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start3) w_state_next = S_WAIT3;
      S_WAIT3: if (w_ack3 || w_tmo) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall_MEM = w_start3 || ((r_state == S_WAIT3) && !w_ack3 && !w_tmo);
  end

  // MEM/WB register: latch whenever not stalled, otherwise inject a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_out_MEMWB      <= '0;
      pc_4_MEMWB         <= '0;
      funct3_MEMWB       <= '0;
      rd_MEMWB           <= '0;
      reg_wr_ctrl_MEMWB  <= '0;
      reg_wr_en_MEMWB    <= 1'b0;
      mem_sel_MEMWB      <= '0;
      byte_offset_MEMWB  <= '0;
      mem3_rd_data_MEMWB <= '0;
      misalign_exc       <= 1'b0;
      bus_err            <= 1'b0;
    end else begin
      misalign_exc <= w_mis;
      bus_err      <= w_tmo;
      if (w_ack3)
        mem3_rd_data_MEMWB <= mem3_rd_data;
      if (!stall_MEM) begin
        ALU_out_MEMWB     <= ALU_out_EXMEM;
        pc_4_MEMWB        <= pc_4_EXMEM;
        funct3_MEMWB      <= funct3_EXMEM;
        rd_MEMWB          <= rd_EXMEM;
        reg_wr_ctrl_MEMWB <= reg_wr_ctrl_EXMEM;
        mem_sel_MEMWB     <= w_sel;
        byte_offset_MEMWB <= w_off;
        reg_wr_en_MEMWB   <= valid_EXMEM & reg_wr_en_EXMEM & ~w_mis & ~w_tmo;
      end else begin
        reg_wr_en_MEMWB   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a stimulus thread pushes expected MEM/WB
// results into a queue, and a monitor pops and checks them as instructions retire.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_EXMEM = 1'b0;
  logic [31:0] ALU_out_EXMEM = '0;
  logic [31:0] rs2_data_EXMEM = '0;
  logic [31:0] pc_4_EXMEM = '0;
  logic [2:0]  funct3_EXMEM = '0;
  logic        mem_rd_en_EXMEM = 1'b0;
  logic        mem_wr_en_EXMEM = 1'b0;
  logic [1:0]  reg_wr_ctrl_EXMEM = '0;
  logic [4:0]  rd_EXMEM = '0;
  logic        reg_wr_en_EXMEM = 1'b0;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;
  logic [3:0]  mem_en;
  logic        mem_wr;
  logic        mem3_req;
  logic        mem3_ack = 1'b0;
  logic [31:0] mem3_rd_data = '0;
  logic        stall_MEM;
  logic        misalign_exc;
  logic        bus_err;
  logic [31:0] ALU_out_MEMWB;
  logic [31:0] pc_4_MEMWB;
  logic [2:0]  funct3_MEMWB;
  logic [4:0]  rd_MEMWB;
  logic [1:0]  reg_wr_ctrl_MEMWB;
  logic        reg_wr_en_MEMWB;
  logic [1:0]  mem_sel_MEMWB;
  logic [1:0]  byte_offset_MEMWB;
  logic [31:0] mem3_rd_data_MEMWB;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .valid_EXMEM(valid_EXMEM),
    .ALU_out_EXMEM(ALU_out_EXMEM), .rs2_data_EXMEM(rs2_data_EXMEM),
    .pc_4_EXMEM(pc_4_EXMEM), .funct3_EXMEM(funct3_EXMEM),
    .mem_rd_en_EXMEM(mem_rd_en_EXMEM), .mem_wr_en_EXMEM(mem_wr_en_EXMEM),
    .reg_wr_ctrl_EXMEM(reg_wr_ctrl_EXMEM), .rd_EXMEM(rd_EXMEM),
    .reg_wr_en_EXMEM(reg_wr_en_EXMEM), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en), .mem_en(mem_en),
    .mem_wr(mem_wr), .mem3_req(mem3_req), .mem3_ack(mem3_ack),
    .mem3_rd_data(mem3_rd_data), .stall_MEM(stall_MEM),
    .misalign_exc(misalign_exc), .bus_err(bus_err),
    .ALU_out_MEMWB(ALU_out_MEMWB), .pc_4_MEMWB(pc_4_MEMWB),
    .funct3_MEMWB(funct3_MEMWB), .rd_MEMWB(rd_MEMWB),
    .reg_wr_ctrl_MEMWB(reg_wr_ctrl_MEMWB), .reg_wr_en_MEMWB(reg_wr_en_MEMWB),
    .mem_sel_MEMWB(mem_sel_MEMWB), .byte_offset_MEMWB(byte_offset_MEMWB),
    .mem3_rd_data_MEMWB(mem3_rd_data_MEMWB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic        rd_en;
    logic        wr_en;
    logic [4:0]  rd;
    logic        rwe;
    logic [1:0]  ctrl;
    int          ack_cyc;   // WAIT3 cycles before the ack; 0 = never ack
    logic [31:0] ack_dat;
    logic [3:0]  e_en;
    logic        e_wr;
    logic [3:0]  e_be;
    logic [31:0] e_data;
    logic        e_wen;
    logic        e_mis;
    logic        e_berr;
    int          e_stalls;
  } vec_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] d3;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [1:0]  ctrl;
    logic [1:0]  sel;
    logic [1:0]  off;
    logic        wen;
    logic        mis;
    logic        berr;
    logic        chk_d3;
    int          stalls;
  } exp_t;

  exp_t        sb_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          ack_cyc = 0;
  logic [31:0] ack_dat = '0;
  vec_t        vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Bank-3 responder: pulses ack after the programmed number of WAIT3 cycles.
  int rsp_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem3_req) rsp_cnt++;
    else          rsp_cnt = 0;
    if (ack_cyc != 0 && mem3_req && rsp_cnt == ack_cyc + 1) begin
      mem3_ack     = 1'b1;
      mem3_rd_data = ack_dat;
    end else begin
      mem3_ack     = 1'b0;
      mem3_rd_data = 32'h0;
    end
  end

  // Monitor: an instruction retires into MEM/WB after a cycle with valid & ~stall.
  bit   mon_pend = 0;
  bit   mon_post = 0;
  int   mon_scnt = 0;
  int   mon_pscnt = 0;
  int   mon_txn = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pend = 0;
      mon_post = 0;
      mon_scnt = 0;
    end else begin
      if (mon_post) begin
        chk("exc_pulse_end", {31'h0, misalign_exc}, 32'h0);
        chk("berr_pulse_end", {31'h0, bus_err}, 32'h0);
        chk("req_low_after", {31'h0, mem3_req}, 32'h0);
        mon_post = 0;
      end
      if (mon_pend) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'h1, 32'h0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("wb_alu", ALU_out_MEMWB, mon_e.alu);
          chk("wb_pc4", pc_4_MEMWB, mon_e.pc4);
          chk("wb_f3", {29'h0, funct3_MEMWB}, {29'h0, mon_e.f3});
          chk("wb_rd", {27'h0, rd_MEMWB}, {27'h0, mon_e.rd});
          chk("wb_ctrl", {30'h0, reg_wr_ctrl_MEMWB}, {30'h0, mon_e.ctrl});
          chk("wb_sel", {30'h0, mem_sel_MEMWB}, {30'h0, mon_e.sel});
          chk("wb_off", {30'h0, byte_offset_MEMWB}, {30'h0, mon_e.off});
          chk("wb_wen", {31'h0, reg_wr_en_MEMWB}, {31'h0, mon_e.wen});
          chk("misalign_exc", {31'h0, misalign_exc}, {31'h0, mon_e.mis});
          chk("bus_err", {31'h0, bus_err}, {31'h0, mon_e.berr});
          chk("stall_cycles", mon_pscnt, mon_e.stalls);
          if (mon_e.chk_d3)
            chk("wb_mem3_data", mem3_rd_data_MEMWB, mon_e.d3);
          $display("txn %0d addr=0x%08h wen=%0b sel=%0d exc=%0b berr=%0b stalls=%0d",
                   mon_txn, ALU_out_MEMWB, reg_wr_en_MEMWB, mem_sel_MEMWB,
                   misalign_exc, bus_err, mon_pscnt);
          mon_txn++;
        end
        mon_pend = 0;
        mon_post = 1;
      end
      if (valid_EXMEM) begin
        if (stall_MEM) begin
          mon_scnt++;
        end else begin
          mon_pend  = 1;
          mon_pscnt = mon_scnt;
          mon_scnt  = 0;
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    valid_EXMEM       = 1'b1;
    ALU_out_EXMEM     = v.addr;
    rs2_data_EXMEM    = v.rs2;
    pc_4_EXMEM        = v.addr ^ 32'hA5A50000;
    funct3_EXMEM      = v.f3;
    mem_rd_en_EXMEM   = v.rd_en;
    mem_wr_en_EXMEM   = v.wr_en;
    reg_wr_ctrl_EXMEM = v.ctrl;
    rd_EXMEM          = v.rd;
    reg_wr_en_EXMEM   = v.rwe;
    ack_cyc           = v.ack_cyc;
    ack_dat           = v.ack_dat;
    e.alu = v.addr;  e.pc4 = v.addr ^ 32'hA5A50000;  e.d3 = v.ack_dat;
    e.f3 = v.f3;  e.rd = v.rd;  e.ctrl = v.ctrl;
    e.sel = v.addr[13:12];  e.off = v.addr[1:0];
    e.wen = v.e_wen;  e.mis = v.e_mis;  e.berr = v.e_berr;
    e.chk_d3 = (v.ack_cyc != 0);  e.stalls = v.e_stalls;
    sb_q.push_back(e);
    @(negedge clk);
    chk("mem_en", {28'h0, mem_en}, {28'h0, v.e_en});
    chk("mem_wr", {31'h0, mem_wr}, {31'h0, v.e_wr});
    chk("byte_en", {28'h0, mem_byte_en}, {28'h0, v.e_be});
    chk("wr_data", mem_wr_data, v.e_data);
    chk("mem_addr", {22'h0, mem_addr}, {22'h0, v.addr[11:2]});
    n = 0;
    while (stall_MEM && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (stall_MEM) chk("stall_release", 32'h1, 32'h0);
    @(posedge clk); #1;
    valid_EXMEM     = 1'b0;
    mem_rd_en_EXMEM = 1'b0;
    mem_wr_en_EXMEM = 1'b0;
    reg_wr_en_EXMEM = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          addr        rs2           f3     rd wr rd    rwe ctrl ack ack_dat       en       wr be       data          wen mis berr stalls
    vecs[0]  = '{32'h3,     32'hAB,       3'b000, 0, 1, 5'd5, 0, 2'd0, 0, 32'h0,        4'b0001, 1, 4'b1000, 32'hABABABAB, 0, 0, 0, 0};
    vecs[1]  = '{32'h3004,  32'h0,        3'b010, 1, 0, 5'd5, 1, 2'd2, 3, 32'hDEADBEEF, 4'b1000, 0, 4'b0000, 32'h0,        1, 0, 0, 4};
    vecs[2]  = '{32'h1001,  32'h0,        3'b001, 1, 0, 5'd6, 1, 2'd2, 0, 32'h0,        4'b0000, 0, 4'b0000, 32'h0,        0, 1, 0, 0};
    vecs[3]  = '{32'h3008,  32'h12345678, 3'b010, 0, 1, 5'd0, 0, 2'd0, 0, 32'h0,        4'b1000, 1, 4'b1111, 32'h12345678, 0, 0, 1, 16};
    vecs[4]  = '{32'h300C,  32'h0,        3'b010, 1, 0, 5'd8, 1, 2'd2, 0, 32'h0,        4'b1000, 0, 4'b0000, 32'h0,        0, 0, 1, 16};
    vecs[5]  = '{32'h3020,  32'h0,        3'b010, 1, 0, 5'd9, 1, 2'd2, 15, 32'hCAFEF00D, 4'b1000, 0, 4'b0000, 32'h0,       1, 0, 0, 16};
    vecs[6]  = '{32'h2002,  32'h0000BEEF, 3'b001, 0, 1, 5'd0, 0, 2'd0, 0, 32'h0,        4'b0100, 1, 4'b1100, 32'hBEEFBEEF, 0, 0, 0, 0};
    vecs[7]  = '{32'h2,     32'h55,       3'b010, 0, 1, 5'd0, 0, 2'd0, 0, 32'h0,        4'b0000, 0, 4'b0000, 32'h55,       0, 1, 0, 0};
    vecs[8]  = '{32'h3003,  32'h0,        3'b100, 1, 0, 5'd10, 1, 2'd2, 1, 32'hA5,      4'b1000, 0, 4'b0000, 32'h0,        1, 0, 0, 2};
    vecs[9]  = '{32'h0,     32'h0,        3'b010, 1, 0, 5'd7, 1, 2'd2, 0, 32'h0,        4'b0001, 0, 4'b0000, 32'h0,        1, 0, 0, 0};
    vecs[10] = '{32'h3000,  32'h7,        3'b000, 0, 0, 5'd11, 1, 2'd0, 0, 32'h0,       4'b0000, 0, 4'b0000, 32'h07070707, 1, 0, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", {31'h0, reg_wr_en_MEMWB}, 32'h0);
    chk("rst_alu", ALU_out_MEMWB, 32'h0);
    chk("rst_req", {31'h0, mem3_req}, 32'h0);
    chk("rst_exc", {31'h0, misalign_exc}, 32'h0);
    chk("rst_berr", {31'h0, bus_err}, 32'h0);
    chk("rst_d3", mem3_rd_data_MEMWB, 32'h0);
    chk("rst_stall", {31'h0, stall_MEM}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) issue(vecs[i]);

    // Reset asserted while waiting on bank 3 must drop the request at once.
    @(posedge clk); #1;
    valid_EXMEM = 1'b1;  ALU_out_EXMEM = 32'h3000;  funct3_EXMEM = 3'b010;
    mem_rd_en_EXMEM = 1'b1;  mem_wr_en_EXMEM = 1'b0;  reg_wr_en_EXMEM = 1'b1;
    ack_cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("req_before_rst", {31'h0, mem3_req}, 32'h1);
    chk("stall_before_rst", {31'h0, stall_MEM}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("req_async_drop", {31'h0, mem3_req}, 32'h0);
    chk("wen_async_clr", {31'h0, reg_wr_en_MEMWB}, 32'h0);
    valid_EXMEM = 1'b0;  mem_rd_en_EXMEM = 1'b0;  reg_wr_en_EXMEM = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 9; i < 11; i++) issue(vecs[i]);

    repeat (4) @(posedge clk);
    chk("sb_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
